pmem_arbiter: RTL and testbench

// - Shares the single physical-memory port between the fetch-stage I-cache
//   (read only) and the MEM-stage D-cache (read/write) of the LC-3b pipeline.
// - Sits between the two caches and the pmem interface.
// - Registered FSM: one transaction in flight at a time.
// - D-side has priority. A bounded starvation guard keeps fetch making progress.

---
 rtl/pmem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_pmem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single physical-memory port between the I-cache
// (read only) and the D-cache (read/write). One transaction is in flight at a
// time. D-side requests win arbitration, but after STARVE_MAX consecutive D
// grants while I is waiting, I is granted once so fetch keeps making progress.
//
// Optional feature macro: PMEM_ARB_PERF_EN
//   defined   : perf_i_wait / perf_d_wait count requester wait cycles
//               (saturating at 16'hFFFF, cleared only by reset)
//   undefined : both perf outputs are tied to 0 and no counters are built
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no transaction; arbitrate among pending requests
// SERVE_I  | I-cache line read in flight on pmem
// SERVE_D  | D-cache line read or write in flight on pmem

module pmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int LINE_W     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic              busy,
  output logic [15:0]       perf_i_wait,
  output logic [15:0]       perf_d_wait
);

  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                grant_i, grant_d;
  logic                d_pend;

  logic                pmem_read_q,    pmem_read_d;
  logic                pmem_write_q,   pmem_write_d;
  logic [ADDR_W-1:0]   pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0]   pmem_wdata_q,   pmem_wdata_d;
  logic [STARVE_W-1:0] starve_q,       starve_d;

  assign d_pend = d_read | d_write;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, return to IDLE on memory completion
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (d_pend && (!i_read || (starve_q < STARVE_LIM))) begin
          state_d = ST_SERVE_D;
          grant_d = 1'b1;
        end else if (i_read) begin
          state_d = ST_SERVE_I;
          grant_i = 1'b1;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (pmem_resp) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: completion pulses gated by the owning state, read data passed through
  always_comb begin
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    busy    = (state_q != ST_IDLE);
    i_rdata = pmem_rdata;
    d_rdata = pmem_rdata;
    if (state_q == ST_SERVE_I) begin
      i_resp = pmem_resp;
    end
    if (state_q == ST_SERVE_D) begin
      d_resp = pmem_resp;
    end
  end

  // Next values of the pmem request registers and the starvation counter.
  // A simultaneous d_read/d_write is issued as a write.
  always_comb begin
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    starve_d       = starve_q;
    if (grant_d) begin
      pmem_read_d    = ~d_write;
      pmem_write_d   = d_write;
      pmem_address_d = d_address;
      pmem_wdata_d   = d_wdata;
      starve_d       = i_read ? (starve_q + 1'b1) : '0;
    end else if (grant_i) begin
      pmem_read_d    = 1'b1;
      pmem_write_d   = 1'b0;
      pmem_address_d = i_address;
      starve_d       = '0;
    end else if ((state_q != ST_IDLE) && pmem_resp) begin
      pmem_read_d    = 1'b0;
      pmem_write_d   = 1'b0;
    end
  end

  // pmem request registers and starvation counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      starve_q       <= '0;
    end else begin
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      starve_q       <= starve_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

`ifdef PMEM_ARB_PERF_EN
  // A requester is waiting when it asks but is neither owning the port nor
  // being granted on this edge.
  logic        i_wait, d_wait;
  logic [15:0] perf_i_q, perf_i_d;
  logic [15:0] perf_d_q, perf_d_d;

  assign i_wait = i_read && (state_q != ST_SERVE_I) && !grant_i;
  assign d_wait = d_pend && (state_q != ST_SERVE_D) && !grant_d;

  // Saturating wait-cycle counters
  always_comb begin
    perf_i_d = perf_i_q;
    perf_d_d = perf_d_q;
    if (i_wait && (perf_i_q != 16'hFFFF)) begin
      perf_i_d = perf_i_q + 16'd1;
    end
    if (d_wait && (perf_d_q != 16'hFFFF)) begin
      perf_d_d = perf_d_q + 16'd1;
    end
  end

  // Wait-cycle counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
    end
  end

  assign perf_i_wait = perf_i_q;
  assign perf_d_wait = perf_d_q;
`else
  assign perf_i_wait = 16'd0;
  assign perf_d_wait = 16'd0;
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a transaction-level model.
module tb_pmem_arbiter;

  localparam int AW   = 16;
  localparam int LW   = 128;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read, d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          busy;
  logic [15:0]   perf_i_wait, perf_d_wait;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy), .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit            m_busy, m_own_d, m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int            m_starve, m_age, m_lat, next_lat;
  int            m_perf_i, m_perf_d;
  int            grants_m[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_starve = 0; m_perf_i = 0; m_perf_d = 0; m_age = 0;
    end else begin : model_step
      bit gd, gi, d_pend, i_owner, d_owner;
      d_pend  = d_read | d_write;
      gd = 0; gi = 0;
      if (!m_busy) begin
        if (d_pend && (!i_read || m_starve < SMAX)) gd = 1;
        else if (i_read) gi = 1;
      end
      i_owner = m_busy && !m_own_d;
      d_owner = m_busy && m_own_d;
      if (i_read && !i_owner && !gi && m_perf_i < 65535) m_perf_i++;
      if (d_pend && !d_owner && !gd && m_perf_d < 65535) m_perf_d++;
      if (m_busy) begin
        if (pmem_resp) m_busy = 0;
        else m_age++;
      end else if (gd) begin
        m_busy = 1; m_own_d = 1; m_wr = d_write; m_addr = d_address; m_wdata = d_wdata;
        m_starve = i_read ? m_starve + 1 : 0;
        m_age = 0; m_lat = next_lat; grants_m.push_back(1);
      end else if (gi) begin
        m_busy = 1; m_own_d = 0; m_wr = 0; m_addr = i_address;
        m_starve = 0; m_age = 0; m_lat = next_lat; grants_m.push_back(0);
      end
    end
  end

  // ---------------- memory responder and per-cycle compare ----------------
  bit            spurious = 0;
  bit            mem_fix = 0;
  logic [LW-1:0] mem_fix_data;
  bit            last_ir, last_dr, prev_busy;
  int            cyc = 0;
  int            dresp_cyc;
  logic [AW-1:0] dut_grants[$];
  int            dut_gcyc[$];

  task automatic drive_mem();
    if (m_busy) begin
      pmem_resp  = (m_age == m_lat);
      pmem_rdata = mem_fix ? mem_fix_data : rand128();
    end else begin
      pmem_resp  = spurious && ($urandom_range(0, 5) == 0);
      pmem_rdata = rand128();
    end
  endtask

  task automatic check_cycle();
    bit e_ir, e_dr;
    e_ir = m_busy && !m_own_d && pmem_resp;
    e_dr = m_busy && m_own_d && pmem_resp;
    chk("busy", busy, m_busy);
    chk("pmem_read", pmem_read, m_busy && !m_wr);
    chk("pmem_write", pmem_write, m_busy && m_wr);
    if (m_busy) chk("pmem_address", pmem_address, m_addr);
    if (m_busy && m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
    chk("i_resp", i_resp, e_ir);
    chk("d_resp", d_resp, e_dr);
    if (e_ir) chk("i_rdata", i_rdata, pmem_rdata);
    if (e_dr) chk("d_rdata", d_rdata, pmem_rdata);
`ifdef PMEM_ARB_PERF_EN
    chk("perf_i_wait", perf_i_wait, 16'(m_perf_i));
    chk("perf_d_wait", perf_d_wait, 16'(m_perf_d));
`else
    chk("perf_i_wait", perf_i_wait, 0);
    chk("perf_d_wait", perf_d_wait, 0);
`endif
    last_ir = e_ir;
    last_dr = e_dr;
    if (d_resp) dresp_cyc = cyc;
    if (busy && !prev_busy) begin
      dut_grants.push_back(pmem_address);
      dut_gcyc.push_back(cyc);
    end
    prev_busy = busy;
    cyc++;
  endtask

  task automatic begin_cycle();
    drive_mem();
    #1;
    check_cycle();
  endtask

  task automatic end_cycle();
    @(negedge clk);
  endtask

  task automatic tick();
    begin_cycle();
    end_cycle();
  endtask

  task automatic clear_reqs();
    i_read = 0; d_read = 0; d_write = 0;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  // ---------------- stimulus ----------------
  bit i_act, d_act, done;
  int cnt, c0;
  logic [AW-1:0] exp_starve[6];
  int            exp_starve_m[6];

  task automatic new_d();
    int op;
    op = $urandom_range(0, 2);
    d_act = 1;
    d_read = (op != 1);
    d_write = (op != 0);
    d_address = AW'($urandom());
    d_wdata = rand128();
  endtask

  initial begin
    reset_n = 0;
    clear_reqs();
    i_address = '0; d_address = '0; d_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0; next_lat = 1;
    prev_busy = 0;
    @(negedge clk);
    begin_cycle();
    chk("reset busy", busy, 0);
    chk("reset pmem_read", pmem_read, 0);
    chk("reset pmem_write", pmem_write, 0);
    chk("reset perf_i", perf_i_wait, 0);
    end_cycle();
    reset_n = 1;
    tick();

    // single I read
    i_read = 1; i_address = 16'h0040; next_lat = 2;
    mem_fix = 1; mem_fix_data = {16{8'hA5}};
    tick();
    begin_cycle();
    chk("I strobe next cycle", pmem_read, 1);
    chk("I address", pmem_address, 16'h0040);
    end_cycle();
    done = 0;
    for (int n = 0; n < 10 && !done; n++) begin
      begin_cycle();
      if (pmem_resp) begin
        chk("I resp same cycle", i_resp, 1);
        chk("I rdata A5", i_rdata, {16{8'hA5}});
        done = 1;
      end
      end_cycle();
    end
    chk("I read completes", done, 1);
    i_read = 0; mem_fix = 0;
    tick();

    // D write
    d_write = 1; d_address = 16'h1000;
    d_wdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    next_lat = 2;
    tick();
    done = 0; cnt = 0;
    for (int n = 0; n < 10 && !done; n++) begin
      begin_cycle();
      chk("D pmem_write held", pmem_write, 1);
      chk("D address", pmem_address, 16'h1000);
      chk("D wdata", pmem_wdata, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
      if (d_resp) cnt++;
      done = pmem_resp;
      end_cycle();
    end
    d_write = 0;
    for (int n = 0; n < 3; n++) begin
      begin_cycle();
      if (d_resp) cnt++;
      end_cycle();
    end
    chk("D resp pulse count", cnt, 1);

    // priority with 3-cycle memory latency
    do_reset();
    dut_grants.delete(); dut_gcyc.delete();
    c0 = cyc;
    i_read = 1; i_address = 16'h0100;
    d_read = 1; d_address = 16'h0200;
    next_lat = 3;
    done = 0;
    for (int n = 0; n < 30 && !done; n++) begin
      tick();
      if (last_dr) d_read = 0;
      if (last_ir) begin i_read = 0; done = 1; end
    end
    chk("prio completes", done, 1);
    tick();
    chk("prio grant count", dut_grants.size(), 2);
    if (dut_grants.size() >= 2) begin
      chk("prio first is D", dut_grants[0], 16'h0200);
      chk("prio second is I", dut_grants[1], 16'h0100);
      chk("prio D strobe cycle", dut_gcyc[0] - c0, 1);
      chk("prio I strobe cycle", dut_gcyc[1] - c0, 6);
      chk("I after first IDLE", dut_gcyc[1] - dresp_cyc, 2);
    end
`ifdef PMEM_ARB_PERF_EN
    chk("perf_i literal", perf_i_wait, 5);
    chk("perf_d literal", perf_d_wait, 0);
    chk("model perf_i literal", m_perf_i, 5);
`else
    chk("perf_i off", perf_i_wait, 0);
    chk("perf_d off", perf_d_wait, 0);
`endif

    // starvation guard
    do_reset();
    dut_grants.delete(); dut_gcyc.delete(); grants_m.delete();
    i_read = 1; i_address = 16'h3000;
    d_read = 1; d_address = 16'h2000;
    next_lat = 1;
    for (int n = 0; n < 80 && dut_grants.size() < 6; n++) begin
      tick();
      if (last_ir) i_read = 0;
    end
    d_read = 0; i_read = 0;
    for (int n = 0; n < 5; n++) tick();
    exp_starve = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h3000, 16'h2000};
    exp_starve_m = '{1, 1, 1, 1, 0, 1};
    chk("starve grant count", dut_grants.size(), 6);
    for (int k = 0; k < 6 && k < dut_grants.size(); k++)
      chk($sformatf("starve grant %0d", k), dut_grants[k], exp_starve[k]);
    for (int k = 0; k < 6 && k < grants_m.size(); k++)
      chk($sformatf("model starve grant %0d", k), grants_m[k], exp_starve_m[k]);

    // reset in the middle of SERVE_D
    d_read = 1; d_address = 16'h0300; next_lat = 3;
    tick();
    begin_cycle();
    chk("rst pre busy", busy, 1);
    end_cycle();
    reset_n = 0;
    pmem_resp = 1;
    #1;
    chk("rst pmem_read", pmem_read, 0);
    chk("rst pmem_write", pmem_write, 0);
    chk("rst d_resp", d_resp, 0);
    chk("rst busy", busy, 0);
    check_cycle();
    @(negedge clk);
    d_read = 0; pmem_resp = 0; reset_n = 1;
    begin_cycle();
    chk("post reset idle", busy, 0);
    end_cycle();

    // randomized traffic
    do_reset();
    spurious = 1;
    i_act = 0; d_act = 0;
    for (int n = 0; n < 3000; n++) begin
      next_lat = $urandom_range(0, 3);
      tick();
      if (last_ir) begin
        i_act = 0; i_read = 0;
      end else if (!i_act) begin
        if ($urandom_range(0, 3) == 0) begin
          i_act = 1; i_read = 1; i_address = AW'($urandom());
        end
      end else if (m_busy && !m_own_d) begin
        i_address = AW'($urandom());
        if ($urandom_range(0, 15) == 0) i_read = 0;
      end
      if (last_dr) begin
        if ($urandom_range(0, 2) == 0) new_d();
        else begin d_act = 0; d_read = 0; d_write = 0; end
      end else if (!d_act) begin
        if ($urandom_range(0, 3) == 0) new_d();
      end else if (m_busy && m_own_d) begin
        d_address = AW'($urandom());
        d_wdata = rand128();
        if ($urandom_range(0, 15) == 0) begin d_read = 0; d_write = 0; end
      end
    end
    clear_reqs();
    spurious = 0;
    for (int n = 0; n < 8; n++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
